fpadd_scheduler: RTL and testbench

- Shares one FP32 adder instance (registered output, fixed latency) between NUM_REQ requesters.
- Each requester sees a valid/ready request port. Grants are round-robin, at most one issue per cycle.
- Operands are registered into the adder. Each operation is tracked with a requester-ID shift pipeline.
- Results come back on a common registered response bus tagged with the requester ID. Includes enable/drain control, busy flag and an issued-operation counter.

---
 rtl/fpadd_scheduler.sv | 140 ++++++++++++++
 tb/tb_fpadd_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_scheduler.sv
// fpadd_scheduler: shares one pipelined FP32 adder between NUM_REQ requesters.
// Round-robin grant, at most one issue per cycle. The requester ID travels
// alongside each operation through a tag pipeline, and the result returns on a
// common response bus tagged with that ID.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   en                1 = grants allowed, 0 = no new grants (in-flight ops drain)
//   req_valid/a/b     per-requester request, operands packed 32 bits per requester
//   req_ready         one-hot grant (combinational)
//   add_a/add_b       registered operands to the adder
//   add_result        adder output, valid ADDER_LATENCY cycles after add_a/add_b
//   rsp_valid/id/data registered response, one pulse per op, no backpressure
//   busy              combinational: any op issued but not yet responded
//   issue_count       handshakes since reset (wraps)
module fpadd_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned ADDER_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [31:0]             add_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy,
  output logic [31:0]             issue_count
);

  localparam int unsigned STAGES = ADDER_LATENCY + 1;
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]      rr_ptr;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_found;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_id;
  logic                 handshake;
  logic [31:0]          sel_a;
  logic [31:0]          sel_b;

  logic [STAGES-1:0]    tag_valid;
  logic [ID_W-1:0]      tag_id [STAGES];

  // Rotate requests so that bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    valid_dbl   = {req_valid, req_valid};
    valid_rot   = NUM_REQ'(valid_dbl >> rr_ptr);
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr} + (ID_W+1)'(i);
      end
    end
    if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
    grant_id = grant_sum[ID_W-1:0];
  end

  // Grant is suppressed while disabled or in reset.
  always_comb begin
    req_ready = '0;
    handshake = 1'b0;
    if (en && grant_found && !reset) begin
      req_ready = NUM_REQ'(1) << grant_id;
      handshake = 1'b1;
    end
  end

  // Operand select for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a = req_a[i*32 +: 32];
        sel_b = req_b[i*32 +: 32];
      end
    end
  end

  // Issue: pointer advance, operand registers, issue counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      add_a       <= '0;
      add_b       <= '0;
      issue_count <= '0;
    end else if (handshake) begin
      rr_ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      add_a       <= sel_a;
      add_b       <= sel_b;
      issue_count <= issue_count + 32'd1;
    end
  end

  // Tag pipeline mirrors the adder latency plus the operand register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      for (int s = 0; s < STAGES; s++) tag_id[s] <= '0;
    end else begin
      tag_valid[0] <= handshake;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < STAGES; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // Response register: captures the adder result when the last tag is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_valid[STAGES-1];
      if (tag_valid[STAGES-1]) begin
        rsp_id   <= tag_id[STAGES-1];
        rsp_data <= add_result;
      end
    end
  end

  assign busy = (|tag_valid) | rsp_valid;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Directed testbench for fpadd_scheduler with a behavioural 1-cycle FP32 adder.
module tb_fpadd_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_result = '0;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;
  logic [31:0]           issue_count;

  int tests = 0;
  int fails = 0;

  fpadd_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDER_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Normal-number FP32 <-> real conversion for the adder model.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always @(posedge clk) add_result <= r2f(f2r(add_a) + f2r(add_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  int nrsp;

  initial begin
    reset = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    #2;
    req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", issue_count, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    req_valid = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single op: requester 2, 1.0 + 2.0 = 3.0
    set_op(2, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    check("single_add_a", add_a, 32'h3F800000);
    check("single_busy1", 32'(busy), 32'h1);
    check("single_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    check("single_busy2", 32'(busy), 32'h1);
    tick();
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_rsp_data", rsp_data, 32'h40400000);
    check("single_busy3", 32'(busy), 32'h1);
    check("single_count", issue_count, 32'h1);
    tick();
    check("single_busy_off", 32'(busy), 32'h0);
    check("single_rsp_off", 32'(rsp_valid), 32'h0);

    // Cancellation: requester 0, 1.5 + -1.5 = 0 (rr_ptr is 3, wraps to 0)
    set_op(0, 32'h3FC00000, 32'hBFC00000);
    req_valid = 4'b0001;
    #1;
    check("cancel_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick(); tick();
    check("cancel_rsp_valid", 32'(rsp_valid), 32'h1);
    check("cancel_rsp_id", 32'(rsp_id), 32'h0);
    check("cancel_rsp_data", rsp_data, 32'h00000000);
    check("cancel_count", issue_count, 32'h2);
    idle(3);

    // Fairness from reset: all four valid for 8 cycles
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 32'h3F800000, 32'h3F800000);
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 3) begin
        check($sformatf("fair_rsp_valid%0d", k), 32'(rsp_valid), 32'h1);
        check($sformatf("fair_rsp_id%0d", k), 32'(rsp_id), 32'((k - 3) % 4));
      end
      if (k == 3) check("fair_rsp_data", rsp_data, 32'h40000000);
      tick();
    end
    check("fair_count", issue_count, 32'd8);
    idle(3);

    // Skip / wrap: move rr_ptr to 3, then only requester 1 valid
    req_valid = 4'b0100; #1;
    check("skip_pre", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0010; #1;
    check("skip_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1001; #1;
    check("wrap_grant3", 32'(req_ready), 32'h8);
    tick(); #1;
    check("wrap_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0101; #1;
    check("ptr_after_wrap", 32'(req_ready), 32'h4);
    tick();
    idle(5);
    check("skip_count", issue_count, 32'd13);

    // Enable drain: 3 back-to-back issues, then en low with all valid
    nrsp = 0;
    for (int k = 0; k < 10; k++) begin
      en = (k < 3);
      req_valid = 4'hF;
      #1;
      if (k >= 3) check($sformatf("drain_ready%0d", k), 32'(req_ready), 32'h0);
      if (rsp_valid) nrsp++;
      if (k == 5) check("drain_busy_last", 32'(busy), 32'h1);
      if (k == 6) check("drain_busy_fall", 32'(busy), 32'h0);
      tick();
    end
    check("drain_nrsp", 32'(nrsp), 32'd3);
    check("drain_count", issue_count, 32'd16);
    en = 1'b1;
    idle(3);

    // Reset mid-flight: two handshakes, reset while first response is out
    req_valid = 4'hF;
    tick(); tick();
    req_valid = '0;
    tick();
    check("midrst_pre_rsp", 32'(rsp_valid), 32'h1);
    #2 reset = 1'b1;
    req_valid = 4'hF;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_count", issue_count, 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    tick();
    reset = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) nrsp++;
      tick();
    end
    check("midrst_no_rsp", 32'(nrsp), 32'h0);
    check("midrst_idle_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
